// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the PWM generator/capture pair: the capture FSM
//   state encoding and a helper returning the all-ones value of an N-bit
//   counter, which is the timeout threshold of the capture counter.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_t;

    // Largest value an unsigned counter of width cnt_w can hold.
    function automatic logic [63:0] cnt_max(input int cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// pwm_sync
//   Multi-flop synchronizer that brings the asynchronous PWM pin into the ck
//   domain. Every flop clears on reset.
// Ports
//   ck     in  system clock
//   rst_n  in  synchronous reset, active-low
//   d      in  asynchronous input
//   s      out synchronized output (d delayed by SYNC_STAGES flops)
module pwm_sync #(
    parameter int SYNC_STAGES = 2   // at least 2 for metastability settling
) (
    input  logic ck,
    input  logic rst_n,
    input  logic d,
    output logic s
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic [SYNC_STAGES-1:0] chain_next;

    // Stage 0 samples the pin; each later stage samples its predecessor.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign chain_next[gi] = d;
            end else begin : g_rest
                assign chain_next[gi] = chain_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= chain_next;
        end
    end

    assign s = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
//   Samples an external PWM pin and measures, in ck cycles, the high time and
//   the period of each complete PWM cycle. A cycle is measured from one rising
//   edge to the next; after leaving IDLE the first rising edge only arms the
//   measurement, so a partially observed cycle is never reported.
// Ports
//   ck          in  system clock
//   rst_n       in  synchronous reset, active-low
//   en          in  capture enable; low forces IDLE and holds the results
//   pwm_in      in  asynchronous PWM pin
//   high_cnt    out high time of the last complete cycle
//   period_cnt  out period of the last complete cycle
//   meas_valid  out one-cycle pulse when high_cnt/period_cnt were updated
//   timeout     out one-cycle pulse when no edge arrived for CNT_MAX cycles
//   level       out synchronized pin level (tells 0% from 100% after timeout)
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    logic             s_d_reg;
    logic             rise_reg;
    logic             fall_reg;

    pwm_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] hi_lat_reg, hi_lat_next;
    logic [CNT_W-1:0] high_cnt_reg, high_cnt_next;
    logic [CNT_W-1:0] period_cnt_reg, period_cnt_next;
    logic             meas_valid_reg, meas_valid_next;
    logic             timeout_reg, timeout_next;

    pwm_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .ck    (ck),
        .rst_n (rst_n),
        .d     (pwm_in),
        .s     (s)
    );

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            s_d_reg        <= 1'b0;
            rise_reg       <= 1'b0;
            fall_reg       <= 1'b0;
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            hi_lat_reg     <= '0;
            high_cnt_reg   <= '0;
            period_cnt_reg <= '0;
            meas_valid_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            // Edge strobes are registered; both edges see the same extra
            // delay, so the measured widths are unaffected and the result
            // pulse lands SYNC_STAGES+2 edges after the pin edge.
            s_d_reg        <= s;
            rise_reg       <= s & ~s_d_reg;
            fall_reg       <= ~s & s_d_reg;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            hi_lat_reg     <= hi_lat_next;
            high_cnt_reg   <= high_cnt_next;
            period_cnt_reg <= period_cnt_next;
            meas_valid_reg <= meas_valid_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        hi_lat_next     = hi_lat_reg;
        high_cnt_next   = high_cnt_reg;
        period_cnt_next = period_cnt_reg;
        meas_valid_next = 1'b0;
        timeout_next    = 1'b0;

        if (!en) begin
            state_next  = IDLE;
            cnt_next    = '0;
            hi_lat_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                    if (rise_reg) begin
                        state_next = HIGH;
                        cnt_next   = CNT_ONE;
                    end
                end
                HIGH, LOW: begin
                    // The counter restarts at 1 on a rise so that it equals
                    // the number of cycles since the rise, inclusive.
                    cnt_next = rise_reg ? CNT_ONE : cnt_reg + CNT_ONE;
                    if (state_reg == HIGH && fall_reg) begin
                        state_next  = LOW;
                        hi_lat_next = cnt_reg;
                    end
                    if (state_reg == LOW && rise_reg) begin
                        state_next      = HIGH;
                        high_cnt_next   = hi_lat_reg;
                        period_cnt_next = cnt_reg;
                        meas_valid_next = 1'b1;
                    end
                    // An edge arriving exactly at the limit takes priority.
                    if (!rise_reg && !fall_reg && cnt_reg == CNT_MAX) begin
                        state_next   = IDLE;
                        cnt_next     = '0;
                        timeout_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign high_cnt   = high_cnt_reg;
    assign period_cnt = period_cnt_reg;
    assign meas_valid = meas_valid_reg;
    assign timeout    = timeout_reg;
    assign level      = s;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Directed bench for pwm_capture (CNT_W=8, SYNC_STAGES=2). Expected reports
//   and timeouts are queued when the pin waveform is driven and popped when
//   the DUT pulses meas_valid/timeout; one line is printed per transaction.
module tb_pwm_capture;

    localparam int CNT_W   = 8;
    localparam int SYNC    = 2;
    localparam int LAT     = SYNC + 2;                 // pin rise -> meas_valid
    localparam int TO_LAT  = LAT + (1 << CNT_W) - 1;   // pin rise -> timeout

    logic             ck;
    logic             rst_n;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             timeout;
    logic             level;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .level      (level)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        int hi;
        int per;
    } exp_t;

    exp_t exp_q[$];
    int   to_q[$];
    int   tl_q[$];
    bit   rise_at [0:8191];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   last_hi = 0;
    int   last_per = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sample();
        exp_t e;
        int   t;
        int   l;
        if (meas_valid === 1'b1) begin
            chk("mv_latency", (cyc >= LAT) ? 32'(rise_at[cyc-LAT]) : 32'd0, 32'd1);
            if (exp_q.size() == 0) begin
                chk("mv_unexpected", 32'(meas_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("high_cnt", 32'(high_cnt), 32'(e.hi));
                chk("period_cnt", 32'(period_cnt), 32'(e.per));
                last_hi  = e.hi;
                last_per = e.per;
            end
            $display("cyc %0d report high_cnt=%0d period_cnt=%0d", cyc, high_cnt, period_cnt);
        end
        if (timeout === 1'b1) begin
            if (to_q.size() == 0) begin
                chk("to_unexpected", 32'(timeout), 32'd0);
            end else begin
                t = to_q.pop_front();
                l = tl_q.pop_front();
                chk("to_cycle", 32'(cyc), 32'(t));
                chk("to_level", 32'(level), 32'(l));
                chk("to_hold_hi", 32'(high_cnt), 32'(last_hi));
                chk("to_hold_per", 32'(period_cnt), 32'(last_per));
            end
            $display("cyc %0d timeout level=%0d high_cnt=%0d period_cnt=%0d", cyc, level, high_cnt, period_cnt);
        end
    endtask

    task automatic cycle(input logic p);
        if (p && !pwm_in) rise_at[cyc] = 1'b1;
        pwm_in = p;
        @(posedge ck);
        #1;
        cyc++;
        sample();
    endtask

    task automatic period(input int h, input int l, input bit rep);
        exp_t e;
        if (rep) begin
            e.hi  = h;
            e.per = h + l;
            exp_q.push_back(e);
        end
        repeat (h) cycle(1'b1);
        repeat (l) cycle(1'b0);
    endtask

    task automatic expect_timeout(input int lvl);
        to_q.push_back(cyc + TO_LAT);
        tl_q.push_back(lvl);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        pwm_in = 1'b0;

        // Reset state
        repeat (3) cycle(1'b0);
        chk("rst_high_cnt", 32'(high_cnt), 32'd0);
        chk("rst_period_cnt", 32'(period_cnt), 32'd0);
        chk("rst_meas_valid", 32'(meas_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_level", 32'(level), 32'd0);

        // 30/70 steady stream: first report after the second rise
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (5) cycle(1'b0);
        repeat (3) period(30, 70, 1'b1);

        // Duty change to 80/20
        repeat (2) period(80, 20, 1'b1);

        // Pin stuck high: closes the last 80/20 cycle, then times out
        expect_timeout(1);
        repeat (300) cycle(1'b1);
        chk("stuck_hi_level", 32'(level), 32'd1);
        repeat (10) cycle(1'b0);

        // Pin stuck low: arming rise, short high, then times out
        expect_timeout(0);
        period(10, 300, 1'b0);
        chk("stuck_lo_level", 32'(level), 32'd0);

        // Enable dropped during HIGH: that cycle is never reported
        period(30, 70, 1'b1);
        period(30, 70, 1'b1);
        repeat (15) cycle(1'b1);
        en = 1'b0;
        repeat (5) cycle(1'b1);
        chk("en_hold_hi", 32'(high_cnt), 32'(last_hi));
        chk("en_hold_per", 32'(period_cnt), 32'(last_per));
        repeat (5) cycle(1'b0);
        en = 1'b1;
        repeat (65) cycle(1'b0);
        period(30, 70, 1'b1);
        period(40, 60, 1'b1);

        // Reset pulse mid-LOW
        repeat (50) cycle(1'b1);
        repeat (20) cycle(1'b0);
        rst_n = 1'b0;
        cycle(1'b0);
        chk("mid_rst_high_cnt", 32'(high_cnt), 32'd0);
        chk("mid_rst_period_cnt", 32'(period_cnt), 32'd0);
        chk("mid_rst_meas_valid", 32'(meas_valid), 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        last_hi  = 0;
        last_per = 0;
        rst_n = 1'b1;
        repeat (29) cycle(1'b0);

        // Fastest waveform: 1 high, 1 low
        repeat (12) period(1, 1, 1'b1);
        period(1, 1, 1'b0);
        repeat (20) cycle(1'b0);

        chk("reports_pending", 32'(exp_q.size()), 32'd0);
        chk("timeouts_pending", 32'(to_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
